// File: rtl/upd77c25_pkg.sv
// upd77c25_pkg: shared widths and loader state encoding for the upd77c25 DSP boot path
package upd77c25_pkg;
  localparam int PGM_AW = 11;
  localparam int DAT_AW = 10;
  localparam int PGM_DW = 24;
  localparam int DAT_DW = 16;
  typedef enum logic [3:0] {IDLE, P0, P1, P2, PWR, D0, D1, DWR, DONE} state_t;
endpackage

// File: rtl/upd77c25_loader.sv
// upd77c25_loader: assembles the boot byte stream into program/data words and holds the core in reset until loaded
module upd77c25_loader
  import upd77c25_pkg::*;
#(
  parameter int PGM_WORDS = 2048,
  parameter int DAT_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              pgm_wr,
  output logic [PGM_DW-1:0] pgm_di,
  output logic [PGM_AW-1:0] pgm_wr_addr,
  output logic              dat_wr,
  output logic [DAT_DW-1:0] dat_di,
  output logic [DAT_AW-1:0] dat_wr_addr,
  output logic              dsp_rst,
  output logic              busy,
  output logic              done
);
  state_t     state;
  logic [7:0] lo_byte;
  logic [7:0] mid_byte;
  logic       take;
  logic       pgm_last;
  logic       dat_last;
  assign take       = byte_valid && byte_ready;
  assign pgm_last   = pgm_wr_addr == PGM_AW'(PGM_WORDS - 1);
  assign dat_last   = dat_wr_addr == DAT_AW'(DAT_WORDS - 1);
  // every output decodes from registered state so nothing leans on byte_valid
  assign byte_ready = state inside {P0, P1, P2, D0, D1};
  assign pgm_wr     = state == PWR;
  assign dat_wr     = state == DWR;
  assign busy       = state inside {P0, P1, P2, PWR, D0, D1, DWR};
  assign done       = state == DONE;
  assign dsp_rst    = state != DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lo_byte     <= '0;
      mid_byte    <= '0;
      pgm_di      <= '0;
      dat_di      <= '0;
      pgm_wr_addr <= '0;
      dat_wr_addr <= '0;
    end else if (abort) begin
      state       <= IDLE;
      pgm_wr_addr <= '0;
      dat_wr_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state       <= P0;
          pgm_wr_addr <= '0;
          dat_wr_addr <= '0;
        end
        P0: if (take) begin
          lo_byte <= byte_in;
          state   <= P1;
        end
        P1: if (take) begin
          mid_byte <= byte_in;
          state    <= P2;
        end
        P2: if (take) begin
          pgm_di <= {byte_in, mid_byte, lo_byte};
          state  <= PWR;
        end
        PWR: begin
          state       <= pgm_last ? D0 : P0;
          pgm_wr_addr <= pgm_last ? pgm_wr_addr : pgm_wr_addr + PGM_AW'(1);
        end
        D0: if (take) begin
          lo_byte <= byte_in;
          state   <= D1;
        end
        D1: if (take) begin
          dat_di <= {byte_in, lo_byte};
          state  <= DWR;
        end
        DWR: begin
          state       <= dat_last ? DONE : D0;
          dat_wr_addr <= dat_last ? dat_wr_addr : dat_wr_addr + DAT_AW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_upd77c25_loader.sv
// tb_upd77c25_loader: directed stream loads with a write-strobe scoreboard for upd77c25_loader
module tb_upd77c25_loader;
  typedef struct packed {
    logic        dat;
    logic [10:0] addr;
    logic [23:0] data;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        abort = 0;
  logic [7:0]  byte_in = 0;
  logic        byte_valid = 0;
  logic        byte_ready;
  logic        pgm_wr;
  logic [23:0] pgm_di;
  logic [10:0] pgm_wr_addr;
  logic        dat_wr;
  logic [15:0] dat_di;
  logic [9:0]  dat_wr_addr;
  logic        dsp_rst;
  logic        busy;
  logic        done;
  int          errors = 0;
  int          checks = 0;
  exp_t        q[$];
  logic [7:0]  stream [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
  upd77c25_loader #(.PGM_WORDS(2), .DAT_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .pgm_wr(pgm_wr), .pgm_di(pgm_di), .pgm_wr_addr(pgm_wr_addr),
    .dat_wr(dat_wr), .dat_di(dat_di), .dat_wr_addr(dat_wr_addr),
    .dsp_rst(dsp_rst), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  // monitor: every write strobe must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n && (pgm_wr || dat_wr)) begin
      exp_t got;
      got = pgm_wr ? {1'b0, pgm_wr_addr, pgm_di} : {1'b1, 1'b0, dat_wr_addr, 8'h00, dat_di};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL strobe: unexpected write got=%h required=none", got);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL strobe: got=%h required=%h", got, e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h required=%h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_in = b;
    byte_valid = 1;
    while (!byte_ready && n < 50) begin
      tick();
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: got=timeout required=byte_ready");
    end else tick();
    byte_valid = 0;
  endtask
  task automatic send_stream(input int gap, input int first, input int last);
    for (int i = first; i < last; i++) begin
      if (i == 2 || i == 5) q.push_back({1'b0, 11'(i / 3), stream[i], stream[i-1], stream[i-2]});
      if (i == 7 || i == 9) q.push_back({1'b1, 11'((i - 6) / 2), 8'h00, stream[i], stream[i-1]});
      send_byte(stream[i]);
      repeat (gap) tick();
    end
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk("done_reached", {done, dsp_rst, busy}, 3'b100);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1);
  end
  initial begin
    int cyc;
    #12;
    chk("reset_ctrl", {dsp_rst, busy, done, byte_ready, pgm_wr, dat_wr}, 6'b100000);
    chk("reset_data", {pgm_di, dat_di, pgm_wr_addr, dat_wr_addr}, 0);
    rst_n = 1;
    tick();
    chk("idle_ctrl", {dsp_rst, busy, done, byte_ready}, 4'b1000);
    // continuous stream, DONE on the 14th edge after START
    do_start();
    fork
      send_stream(0, 0, 10);
      begin
        cyc = 0;
        while (!done && cyc < 40) begin
          tick();
          cyc++;
        end
      end
    join
    chk("done_cycle", cyc, 14);
    chk("done_dsp_rst", {done, dsp_rst}, 2'b10);
    chk("queue_empty_1", q.size(), 0);
    // restart from DONE with gapped bytes
    do_start();
    chk("restart_rst", {dsp_rst, busy, done}, 3'b110);
    send_stream(3, 0, 10);
    wait_done();
    // abort after two program bytes
    do_start();
    send_stream(0, 0, 2);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_idle", {dsp_rst, busy, done, byte_ready}, 4'b1000);
    chk("abort_addr", {pgm_wr_addr, dat_wr_addr}, 0);
    repeat (3) tick();
    do_start();
    send_stream(0, 0, 10);
    wait_done();
    // START mid-load is ignored
    do_start();
    send_stream(0, 0, 1);
    do_start();
    chk("start_busy_ign", {busy, byte_ready}, 2'b11);
    send_stream(0, 1, 10);
    wait_done();
    // START and ABORT together: ABORT wins
    do_start();
    send_stream(0, 0, 1);
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    chk("start_abort", {dsp_rst, busy, done}, 3'b100);
    // nRST during the data phase
    do_start();
    send_stream(0, 0, 7);
    #3;
    rst_n = 0;
    #1;
    chk("nrst_ctrl", {dsp_rst, busy, done, byte_ready, pgm_wr, dat_wr}, 6'b100000);
    chk("nrst_data", {pgm_di, dat_di, pgm_wr_addr, dat_wr_addr}, 0);
    repeat (3) tick();
    rst_n = 1;
    repeat (4) tick();
    chk("nrst_after", {dsp_rst, busy, done}, 3'b100);
    chk("queue_empty_end", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
